// File: rtl/div_arb_pkg.sv
// Shared types and sizing helpers for the divider arbiter.
package div_arb_pkg;

   localparam int DEF_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE,
      RESP
   } state_t;

   // Index width; a two-requester arbiter still needs one bit of id.
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/divider_arbiter_rr.sv
// Combinational round-robin pick: first pending request after ptr, wrapping.
module rr_arbiter_n #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   int j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one start/ready divider among NREQ requesters with round-robin grants.
// Optional DIV_ZERO_BYPASS_EN answers zero-divisor requests without using the divider.
//
// state     | meaning
// IDLE      | waiting for a pending request while the divider is idle
// START     | div_st pulse, operands presented
// WAIT_BUSY | waiting for the divider to drop div_ready
// WAIT_DONE | waiting for div_ready to return, then capture result
// RESP      | response held until rsp_ready
module divider_arbiter
   import div_arb_pkg::*;
#(
   parameter int  NREQ        = 4,
   parameter int  W           = DEF_W,
   parameter int  TIMEOUT_CYC = 64,
   localparam int IDW         = id_w(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_dividend,
   input  logic [NREQ*W-1:0] req_divisor,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [IDW-1:0]  rsp_id,
   output logic [W-1:0]    rsp_quot,
   output logic [W-1:0]    rsp_rem,
   output logic            rsp_err,
   output logic            div_st,
   output logic [W-1:0]    div_q_in,
   output logic [W-1:0]    div_m_in,
   input  logic [W-1:0]    div_q_out,
   input  logic [W-1:0]    div_a_out,
   input  logic            div_ready
);

   localparam int           TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  g_idx;
   logic            g_any;
   logic [W-1:0]    op_q, op_m;
   logic [W-1:0]    sel_q, sel_m;
   logic [TW-1:0]   tmo_cnt;

   rr_arbiter_n #(.NREQ(NREQ), .IDW(IDW)) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (g_idx),
      .any   (g_any)
   );

   assign sel_q    = req_dividend[int'(g_idx)*W +: W];
   assign sel_m    = req_divisor[int'(g_idx)*W +: W];
   assign div_q_in = op_q;
   assign div_m_in = op_m;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= IDW'(NREQ - 1);
         req_ready <= '0;
         div_st    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_quot  <= '0;
         rsp_rem   <= '0;
         rsp_err   <= 1'b0;
         op_q      <= '0;
         op_m      <= '0;
         tmo_cnt   <= '0;
      end else begin
         req_ready <= '0;
         div_st    <= 1'b0;
         case (state)
            IDLE: begin
               if (g_any && div_ready) begin
                  req_ready <= grant;
                  ptr       <= g_idx;
                  rsp_id    <= g_idx;
                  op_q      <= sel_q;
                  op_m      <= sel_m;
`ifdef DIV_ZERO_BYPASS_EN
                  if (sel_m == '0) begin
                     rsp_quot  <= '1;
                     rsp_rem   <= sel_q;
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     div_st <= 1'b1;
                     state  <= START;
                  end
`else
                  div_st <= 1'b1;
                  state  <= START;
`endif
               end
            end
            START: begin
               tmo_cnt <= '0;
               state   <= WAIT_BUSY;
            end
            WAIT_BUSY, WAIT_DONE: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (state == WAIT_BUSY && !div_ready) begin
                  state <= WAIT_DONE;
               end else if (state == WAIT_DONE && div_ready) begin
                  rsp_quot  <= div_q_out;
                  rsp_rem   <= div_a_out;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (tmo_cnt == TMO_LAST) begin
                  // Divider never answered: report an empty errored result.
                  rsp_quot  <= '0;
                  rsp_rem   <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a behavioural start/ready divider model.
module tb_divider_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [31:0] req_dividend = {8'd9, 8'd255, 8'd200, 8'd100};
   logic [31:0] req_divisor  = {8'd10, 8'd16, 8'd9, 8'd7};
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_quot, rsp_rem;
   logic        rsp_err;
   logic        div_st;
   logic [7:0]  div_q_in, div_m_in;
   logic [7:0]  div_q_out = '0;
   logic [7:0]  div_a_out = '0;
   logic        div_ready = 1'b1;

   int errors = 0;
   int checks = 0;

   logic       hang = 1'b0;
   logic       busy = 1'b0;
   int         mcnt = 0;
   int         pulses = 0;
   logic [7:0] a_l = '0, m_l = '0;

   always #5 clk = ~clk;

   divider_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
      .div_st(div_st), .div_q_in(div_q_in), .div_m_in(div_m_in),
      .div_q_out(div_q_out), .div_a_out(div_a_out), .div_ready(div_ready)
   );

   // Divider model: busy for a few cycles after div_st, zero divisor gives all-ones/dividend.
   always @(posedge clk) begin
      if (div_st) pulses <= pulses + 1;
      if (!busy) begin
         if (div_st && !hang) begin
            busy      <= 1'b1;
            div_ready <= 1'b0;
            mcnt      <= 6;
            a_l       <= div_q_in;
            m_l       <= div_m_in;
         end
      end else if (mcnt == 0) begin
         busy      <= 1'b0;
         div_ready <= 1'b1;
         div_q_out <= (m_l == 0) ? 8'hFF : a_l / m_l;
         div_a_out <= (m_l == 0) ? a_l : a_l % m_l;
      end else begin
         mcnt <= mcnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_grant(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (req_ready == '0 && n < 50);
      chk({tag, "_grant_seen"}, 32'(req_ready != '0), 1);
   endtask

   task automatic wait_rsp(input string tag);
      int n = 0;
      while (!rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_rsp_seen"}, 32'(rsp_valid), 1);
   endtask

   task automatic accept(input string tag);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_rsp_dropped"}, 32'(rsp_valid), 0);
      rsp_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int          exp_id[5]  = '{0, 1, 2, 3, 0};
      int          exp_q[4]   = '{14, 22, 15, 0};
      int          exp_r[4]   = '{2, 2, 15, 9};
      logic [18:0] snap;
      logic        ok;
      int          n;
      int          p0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_outs", {req_ready, div_st, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err}, 0);
      chk("reset_operands", {div_q_in, div_m_in}, 0);
      rst = 1'b1;
      @(negedge clk);

      // T1: single request 100/7
      req_valid = 4'b0001;
      wait_grant("t1");
      chk("t1_req_ready", 32'(req_ready), 4'b0001);
      chk("t1_div_st", 32'(div_st), 1);
      chk("t1_operands", {div_q_in, div_m_in}, {8'd100, 8'd7});
      req_valid = '0;
      wait_rsp("t1");
      chk("t1_rsp", {rsp_id, rsp_quot, rsp_rem, rsp_err}, {2'd0, 8'd14, 8'd2, 1'b0});
      accept("t1");
      chk("t1_pulses", 32'(pulses), 1);

      // T2: all four held, grants rotate from slot 0
      do_reset();
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_rsp("t2");
         if (i == 4) req_valid = '0;
         chk("t2_id", 32'(rsp_id), exp_id[i]);
         chk("t2_quot_rem", {rsp_quot, rsp_rem}, {8'(exp_q[exp_id[i]]), 8'(exp_r[exp_id[i]])});
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("t2_idle", {29'(0), rsp_valid, div_st, 1'b0}, 0);

      // T3: backpressure, others pending must not be granted
      req_valid = 4'b0100;
      wait_grant("t3");
      chk("t3_req_ready", 32'(req_ready), 4'b0100);
      req_valid = 4'b1011;
      wait_rsp("t3");
      snap = {rsp_id, rsp_quot, rsp_rem, rsp_err};
      chk("t3_rsp", snap, {2'd2, 8'd15, 8'd15, 1'b0});
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if ({rsp_id, rsp_quot, rsp_rem, rsp_err} !== snap || rsp_valid !== 1'b1 || req_ready !== '0)
            ok = 1'b0;
      end
      chk("t3_stable", 32'(ok), 1);
      req_valid = '0;
      accept("t3");

      // T4: divider never goes busy -> timeout after 64 wait cycles
      hang = 1'b1;
      req_valid = 4'b0001;
      wait_grant("t4");
      chk("t4_div_st", 32'(div_st), 1);
      req_valid = '0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 100);
      chk("t4_latency", 32'(n), 65);
      chk("t4_rsp", {rsp_id, rsp_quot, rsp_rem, rsp_err}, {2'd0, 8'd0, 8'd0, 1'b1});
      accept("t4");
      hang = 1'b0;

      // T5: reset while waiting for the divider
      req_valid = 4'b0010;
      wait_grant("t5");
      chk("t5_req_ready", 32'(req_ready), 4'b0010);
      req_valid = '0;
      n = 0;
      while (div_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t5_div_busy", 32'(div_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t5_outs_cleared", {req_ready, div_st, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err}, 0);
      chk("t5_operands_cleared", {div_q_in, div_m_in}, 0);
      @(negedge clk);
      rst = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid || req_ready != '0) ok = 1'b1;
      end
      chk("t5_no_rsp", 32'(ok), 0);

      // T6: zero divisor 55/0 on slot 3
      req_dividend[31:24] = 8'd55;
      req_divisor[31:24]  = 8'd0;
      p0 = pulses;
      req_valid = 4'b1000;
      wait_grant("t6");
      req_valid = '0;
      wait_rsp("t6");
`ifdef DIV_ZERO_BYPASS_EN
      chk("t6_rsp", {rsp_id, rsp_quot, rsp_rem, rsp_err}, {2'd3, 8'hFF, 8'd55, 1'b1});
      chk("t6_no_div_st", 32'(pulses - p0), 0);
`else
      chk("t6_rsp", {rsp_id, rsp_quot, rsp_rem, rsp_err}, {2'd3, 8'hFF, 8'd55, 1'b0});
      chk("t6_div_st", 32'(pulses - p0), 1);
`endif
      accept("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
